// File: rtl/ddr_rd_burst_ctrl.sv
// Frame reader for the DDR-read FIFO. It issues credit-throttled AXI4 AR bursts
// and forwards the returned R beats into the FIFO write port.
module ddr_rd_burst_ctrl #(
    parameter int ADDR_WIDTH       = 28,
    parameter int DATA_WIDTH       = 256,
    parameter int FIFO_DEPTH_WIDTH = 10,
    parameter int BURST_LEN        = 16,
    parameter int MAX_OUTSTANDING  = 2
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst_n,
    input  logic                      frame_start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [23:0]               frame_beats,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [7:0]                arlen,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic                      rlast,
    output logic                      fifo_wr_en,
    output logic [DATA_WIDTH-1:0]     fifo_wr_data,
    input  logic                      fifo_wr_full,
    input  logic [FIFO_DEPTH_WIDTH:0] fifo_wr_water_level,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overflow_err
);
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int BW = FIFO_DEPTH_WIDTH + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = FIFO_DEPTH_WIDTH + 10;
    localparam logic [CW-1:0] CAPACITY = CW'(1) << FIFO_DEPTH_WIDTH;

    typedef enum logic [1:0] {IDLE, CHECK, REQ, DRAIN} state_t;
    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [23:0]           remaining;
    logic [BW-1:0]         beats_out, beats_out_d;
    logic [OW-1:0]         bursts_out, bursts_out_d;
    logic [8:0]            len_c, ar_len;
    logic                  ar_hs, r_beat, credit_ok, frame_done_d, load_ar;

    assign ar_hs   = arvalid & arready;
    assign r_beat  = rvalid & rready;
    assign ar_len  = {1'b0, arlen} + 9'd1;
    assign len_c   = (remaining >= 24'(BURST_LEN)) ? 9'(BURST_LEN) : remaining[8:0];
    assign arvalid = (state == REQ);
    assign busy    = (state != IDLE);

    // +2 reserves room for the output register and the FIFO's level-update lag.
    assign credit_ok = (bursts_out < OW'(MAX_OUTSTANDING)) &&
                       (CW'(fifo_wr_water_level) + CW'(beats_out) + CW'(len_c) + CW'(2) <= CAPACITY);

    always_comb begin
        state_d      = state;
        frame_done_d = 1'b0;
        load_ar      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    if (frame_beats != '0) state_d = CHECK;
                    else                   frame_done_d = 1'b1;
                end
            end
            CHECK: begin
                if (credit_ok) begin
                    state_d = REQ;
                    load_ar = 1'b1;
                end
            end
            REQ: begin
                if (ar_hs) state_d = (remaining == 24'(ar_len)) ? DRAIN : CHECK;
            end
            DRAIN: begin
                if (beats_out == '0) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Same-cycle AR handshake and R beat net out; decrements never go below zero.
    always_comb begin
        beats_out_d  = beats_out + (ar_hs ? BW'(ar_len) : BW'(0));
        bursts_out_d = bursts_out + (ar_hs ? OW'(1) : OW'(0));
        if (r_beat && beats_out_d != '0)          beats_out_d  = beats_out_d - BW'(1);
        if (r_beat && rlast && bursts_out_d != '0) bursts_out_d = bursts_out_d - OW'(1);
    end

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) state <= IDLE;
        else           state <= state_d;
    end

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            addr_q       <= '0;
            remaining    <= '0;
            beats_out    <= '0;
            bursts_out   <= '0;
            araddr       <= '0;
            arlen        <= '0;
            rready       <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            frame_done   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            rready     <= 1'b1;
            fifo_wr_en <= r_beat;
            frame_done <= frame_done_d;
            beats_out  <= beats_out_d;
            bursts_out <= bursts_out_d;
            if (r_beat) fifo_wr_data <= rdata;
            if (state == IDLE && frame_start && frame_beats != '0) begin
                addr_q       <= base_addr;
                remaining    <= frame_beats;
                overflow_err <= 1'b0;
            end
            if (r_beat && fifo_wr_full) overflow_err <= 1'b1;
            if (load_ar) begin
                araddr <= addr_q;
                arlen  <= 8'(len_c - 9'd1);
            end
            if (ar_hs) begin
                addr_q    <= addr_q + ADDR_WIDTH'(32'(ar_len) * BYTES_PER_BEAT);
                remaining <= remaining - 24'(ar_len);
            end
        end
    end
endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// Bench for ddr_rd_burst_ctrl: a reactive DDR/R-channel model with AR and data
// scoreboards, a table of frame vectors, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_ddr_rd_burst_ctrl;
    localparam int AW  = 28;
    localparam int DW  = 256;
    localparam int FDW = 10;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [23:0]   frame_beats = '0;
    logic          arvalid;
    logic          arready = 1'b1;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [DW-1:0] rdata = '0;
    logic          rlast = 1'b0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_wr_full = 1'b0;
    logic [FDW:0]  fifo_wr_water_level = '0;
    logic          busy, frame_done, overflow_err;

    ddr_rd_burst_ctrl dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .frame_start(frame_start),
        .base_addr(base_addr), .frame_beats(frame_beats),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_wr_full(fifo_wr_full), .fifo_wr_water_level(fifo_wr_water_level),
        .busy(busy), .frame_done(frame_done), .overflow_err(overflow_err)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [AW-1:0] base; int beats; int n_ar; int last_len; } vec_t;

    ar_t           exp_ar[$];
    ar_t           pend[$];
    logic [DW-1:0] exp_data[$];
    ar_t           mon_e;
    int checks = 0, errors = 0;
    int cyc = 0, ar_count = 0, wr_count = 0, fd_count = 0, fd_cyc = 0, last_wr_cyc = 0, last_ar_len = 0;
    int beat_no = 0, bidx = 0, full_on = -1;
    bit r_en = 1'b1, r_gaps = 1'b0, r_take = 1'b0, prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [7:0]    prev_len = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge wr_clk) cyc++;

    // Monitor: samples mid-cycle, so a valid&ready seen here completes on the next edge.
    always @(negedge wr_clk) begin
        if (!wr_rst_n) begin
            prev_stall = 1'b0;
            r_take     = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("ar_hold_valid", arvalid, 1'b1);
                chk("ar_hold_addr", araddr, prev_addr);
                chk("ar_hold_len", arlen, prev_len);
            end
            prev_stall = arvalid && !arready;
            prev_addr  = araddr;
            prev_len   = arlen;
            if (arvalid && arready) begin
                ar_count++;
                last_ar_len = int'(arlen);
                pend.push_back('{addr: araddr, len: arlen});
                chk("ar_expected", exp_ar.size() != 0, 1'b1);
                if (exp_ar.size() != 0) begin
                    mon_e = exp_ar.pop_front();
                    chk("ar_addr", araddr, mon_e.addr);
                    chk("ar_len", arlen, mon_e.len);
                end
            end
            if (rvalid && rready) begin
                exp_data.push_back(rdata);
                r_take = 1'b1;
            end
            if (fifo_wr_en) begin
                wr_count++;
                last_wr_cyc = cyc;
                chk("wr_expected", exp_data.size() != 0, 1'b1);
                if (exp_data.size() != 0) chk("wr_data", fifo_wr_data, exp_data.pop_front());
            end
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
        end
    end

    // DDR R-channel model: returns accepted bursts in order.
    always @(posedge wr_clk) begin
        #1;
        if (!wr_rst_n) begin
            pend.delete();
            bidx = 0;
            rvalid = 1'b0; rlast = 1'b0; fifo_wr_full = 1'b0;
        end else begin
            if (r_take) begin
                r_take = 1'b0;
                beat_no++;
                if (rlast) begin
                    if (pend.size() != 0) pend.delete(0);
                    bidx = 0;
                end else bidx++;
            end
            if (r_en && pend.size() != 0 && (!r_gaps || $urandom_range(0, 3) != 0)) begin
                rvalid       = 1'b1;
                rdata        = {8{32'hC0DE_0000 + 32'(beat_no)}};
                rlast        = (bidx == int'(pend[0].len));
                fifo_wr_full = (beat_no == full_on);
            end else begin
                rvalid = 1'b0; rlast = 1'b0; fifo_wr_full = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic model_push(input logic [AW-1:0] base, input int beats);
        logic [AW-1:0] a;
        int rem, len;
        a = base; rem = beats;
        while (rem > 0) begin
            len = (rem > 16) ? 16 : rem;
            exp_ar.push_back('{addr: a, len: 8'(len - 1)});
            a   = a + AW'(len * 32);
            rem = rem - len;
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input int beats);
        base_addr = base; frame_beats = 24'(beats); frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int fd0, input int budget);
        int n;
        n = 0;
        while (fd_count == fd0 && n < budget) begin tick(); n++; end
        chk(name, fd_count - fd0, 1);
    endtask

    task automatic post_frame(input string tag, input int ar0, input int wr0,
                              input int n_ar, input int beats, input bit ovf);
        chk({tag, "_ar_count"}, ar_count - ar0, n_ar);
        chk({tag, "_wr_count"}, wr_count - wr0, beats);
        chk({tag, "_ar_left"}, exp_ar.size(), 0);
        chk({tag, "_data_left"}, exp_data.size(), 0);
        chk({tag, "_done_timing"}, fd_cyc, last_wr_cyc + 1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_overflow"}, overflow_err, ovf);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_arvalid"}, arvalid, 1'b0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_arlen"}, arlen, 0);
        chk({tag, "_rready"}, rready, 1'b0);
        chk({tag, "_fifo_wr_en"}, fifo_wr_en, 1'b0);
        chk({tag, "_fifo_wr_data"}, fifo_wr_data, 0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_overflow_err"}, overflow_err, 1'b0);
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int ar0, wr0, fd0, n;
        vecs[0] = '{base: 28'h0000000, beats: 16,  n_ar: 1, last_len: 15};
        vecs[1] = '{base: 28'h0001000, beats: 1,   n_ar: 1, last_len: 0};
        vecs[2] = '{base: 28'hFFFFFE0, beats: 20,  n_ar: 2, last_len: 3};
        vecs[3] = '{base: 28'h0000040, beats: 33,  n_ar: 3, last_len: 0};
        vecs[4] = '{base: 28'h0200000, beats: 100, n_ar: 7, last_len: 3};

        wr_rst_n = 1'b0;
        tick(3);
        check_idle("reset");
        wr_rst_n = 1'b1;
        tick(2);

        // Basic frame with start latency: busy at T+1, arvalid at T+2.
        ar0 = ar_count; wr0 = wr_count; fd0 = fd_count;
        model_push(28'h100, 40);
        pulse_start(28'h100, 40);
        chk("start_busy", busy, 1'b1);
        chk("start_no_arvalid", arvalid, 1'b0);
        tick();
        chk("first_arvalid", arvalid, 1'b1);
        chk("first_araddr", araddr, 28'h100);
        chk("first_arlen", arlen, 8'd15);
        wait_done("basic_done", fd0, 2000);
        post_frame("basic", ar0, wr0, 3, 40, 1'b0);
        tick();
        chk("basic_done_pulse", frame_done, 1'b0);

        r_gaps = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ar0 = ar_count; wr0 = wr_count; fd0 = fd_count;
            model_push(vecs[i].base, vecs[i].beats);
            pulse_start(vecs[i].base, vecs[i].beats);
            wait_done($sformatf("vec%0d_done", i), fd0, 3000);
            post_frame($sformatf("vec%0d", i), ar0, wr0, vecs[i].n_ar, vecs[i].beats, 1'b0);
            chk($sformatf("vec%0d_last_arlen", i), last_ar_len, vecs[i].last_len);
        end
        r_gaps = 1'b0;

        // Zero-length frame.
        ar0 = ar_count; fd0 = fd_count;
        pulse_start(28'h777, 0);
        chk("zero_done", frame_done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        tick();
        chk("zero_done_pulse", frame_done, 1'b0);
        tick(5);
        chk("zero_no_ar", ar_count - ar0, 0);
        chk("zero_fd_count", fd_count - fd0, 1);

        // frame_start while busy must be ignored.
        ar0 = ar_count; wr0 = wr_count; fd0 = fd_count;
        model_push(28'h8000, 40);
        pulse_start(28'h8000, 40);
        tick(3);
        pulse_start(28'h9990, 5);
        wait_done("busy_done", fd0, 2000);
        post_frame("busy", ar0, wr0, 3, 40, 1'b0);
        tick(10);
        chk("busy_no_extra_done", fd_count - fd0, 1);
        chk("busy_no_extra_ar", ar_count - ar0, 3);

        // Credit throttle, capacity 1024, data held back by the DDR model.
        r_en = 1'b0;
        ar0 = ar_count; wr0 = wr_count; fd0 = fd_count;
        fifo_wr_water_level = 11'd1007;
        model_push(28'h10000, 48);
        pulse_start(28'h10000, 48);
        tick(20);
        chk("thr_1007_ar", ar_count - ar0, 0);
        chk("thr_1007_arvalid", arvalid, 1'b0);
        fifo_wr_water_level = 11'd1006;
        tick(20);
        chk("thr_1006_ar", ar_count - ar0, 1);
        fifo_wr_water_level = 11'd990;
        tick(20);
        chk("thr_990_ar", ar_count - ar0, 2);
        fifo_wr_water_level = 11'd0;
        tick(20);
        chk("thr_outstanding_ar", ar_count - ar0, 2);
        r_en = 1'b1;
        wait_done("thr_done", fd0, 2000);
        post_frame("thr", ar0, wr0, 3, 48, 1'b0);

        // AR backpressure: request must hold steady while arready is low.
        arready = 1'b0;
        ar0 = ar_count; wr0 = wr_count; fd0 = fd_count;
        model_push(28'h20000, 16);
        pulse_start(28'h20000, 16);
        n = 0;
        while (!arvalid && n < 10) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("bp_arvalid", arvalid, 1'b1);
            chk("bp_araddr", araddr, 28'h20000);
            chk("bp_arlen", arlen, 8'd15);
            tick();
        end
        chk("bp_no_hs", ar_count - ar0, 0);
        arready = 1'b1;
        wait_done("bp_done", fd0, 2000);
        post_frame("bp", ar0, wr0, 1, 16, 1'b0);

        // Overflow: one beat arrives with the FIFO full.
        full_on = beat_no + 5;
        ar0 = ar_count; wr0 = wr_count; fd0 = fd_count;
        model_push(28'h30000, 16);
        pulse_start(28'h30000, 16);
        wait_done("ovf_done", fd0, 2000);
        post_frame("ovf", ar0, wr0, 1, 16, 1'b1);
        tick(5);
        chk("ovf_sticky", overflow_err, 1'b1);
        full_on = -1;
        ar0 = ar_count; wr0 = wr_count; fd0 = fd_count;
        model_push(28'h31000, 16);
        pulse_start(28'h31000, 16);
        chk("ovf_cleared", overflow_err, 1'b0);
        wait_done("ovf2_done", fd0, 2000);
        post_frame("ovf2", ar0, wr0, 1, 16, 1'b0);

        // Reset mid-frame after the second AR, then restart from a new base.
        r_en = 1'b0;
        ar0 = ar_count;
        model_push(28'h40000, 64);
        pulse_start(28'h40000, 64);
        n = 0;
        while (ar_count - ar0 < 2 && n < 50) begin tick(); n++; end
        chk("rst_two_ars", ar_count - ar0, 2);
        wr_rst_n = 1'b0;
        tick();
        check_idle("midrst");
        exp_ar.delete();
        exp_data.delete();
        tick();
        wr_rst_n = 1'b1;
        r_en = 1'b1;
        tick(2);
        ar0 = ar_count; wr0 = wr_count; fd0 = fd_count;
        model_push(28'h50000, 20);
        pulse_start(28'h50000, 20);
        tick();
        chk("restart_araddr", araddr, 28'h50000);
        wait_done("restart_done", fd0, 2000);
        post_frame("restart", ar0, wr0, 2, 20, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
